// File: rtl/elevator_pkg.sv
// Shared types and sizing for the elevator scheduler.
package elevator_pkg;

  localparam int unsigned FLOOR_W    = 3;
  localparam int unsigned NUM_FLOORS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

endpackage

// File: rtl/tick_timer.sv
// Tick-strobe interval counter; load wins over tick, so a strobe in the
// loading cycle does not count toward the new interval.
module tick_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         tick,
  input  logic [W-1:0] last,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  assign done = tick && (cnt_q == last);

  // Next count: clear on load or on terminal tick, otherwise advance on tick.
  always_comb begin
    cnt_d = cnt_q;
    if (load || done) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/elevator_scheduler.sv
// Single-car SCAN scheduler: latches floor calls, sequences travel and door
// intervals off the tick strobe, registered floor index for the floor demux.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int unsigned FLOORS       = NUM_FLOORS,
  parameter int unsigned TRAVEL_TICKS = 4,
  parameter int unsigned DOOR_TICKS   = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic [FLOORS-1:0]  req,
  output logic [3:0]         floor_sel,
  output logic [FLOOR_W-1:0] cur_floor,
  output logic               dir_up,
  output logic               moving,
  output logic               door_open,
  output logic [FLOORS-1:0]  pending
);

  localparam int unsigned MAX_TICKS = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
  localparam int unsigned TW        = $clog2(MAX_TICKS + 1);
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_TICKS - 1);
  localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_TICKS - 1);

  state_t             state_q, state_d;
  logic [FLOOR_W-1:0] cur_floor_q, cur_floor_d, next_floor;
  logic [3:0]         floor_sel_q, floor_sel_d;
  logic               dir_up_q, dir_up_d;
  logic               moving_q, moving_d;
  logic               door_open_q, door_open_d;
  logic [FLOORS-1:0]  pending_q, pending_d;
  logic [FLOORS-1:0]  set_mask, clr_mask;
  logic [FLOORS-1:0]  above_mask, below_mask;
  logic               above, below, ahead, behind;
  logic               timer_load, timer_done;
  logic [TW-1:0]      timer_last;

  assign timer_last = (state_q == DOOR) ? DOOR_LAST : TRAVEL_LAST;

  tick_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (timer_load),
    .tick  (tick),
    .last  (timer_last),
    .done  (timer_done)
  );

  // Pending calls strictly above / below the car.
  always_comb begin
    above_mask = '0;
    below_mask = '0;
    for (int unsigned i = 0; i < FLOORS; i++) begin
      above_mask[i] = (i > 32'(cur_floor_q));
      below_mask[i] = (i < 32'(cur_floor_q));
    end
    above  = |(pending_q & above_mask);
    below  = |(pending_q & below_mask);
    ahead  = dir_up_q ? above : below;
    behind = dir_up_q ? below : above;
  end

  // Next-state, call latching and timer control.
  always_comb begin
    state_d     = state_q;
    cur_floor_d = cur_floor_q;
    dir_up_d    = dir_up_q;
    moving_d    = moving_q;
    door_open_d = door_open_q;
    set_mask    = req;
    clr_mask    = '0;
    timer_load  = 1'b0;
    next_floor  = dir_up_q ? (cur_floor_q + FLOOR_W'(1)) : (cur_floor_q - FLOOR_W'(1));

    unique case (state_q)
      IDLE: begin
        timer_load = 1'b1;
        if (pending_q[cur_floor_q]) begin
          state_d                = DOOR;
          door_open_d            = 1'b1;
          clr_mask[cur_floor_q]  = 1'b1;
        end else if (above) begin
          state_d  = MOVE;
          dir_up_d = 1'b1;
          moving_d = 1'b1;
        end else if (below) begin
          state_d  = MOVE;
          dir_up_d = 1'b0;
          moving_d = 1'b1;
        end
      end
      MOVE: begin
        if (timer_done) begin
          cur_floor_d = next_floor;
          timer_load  = 1'b1;
          if (pending_q[next_floor]) begin
            state_d              = DOOR;
            moving_d             = 1'b0;
            door_open_d          = 1'b1;
            clr_mask[next_floor] = 1'b1;
          end
        end
      end
      DOOR: begin
        // A call at the open floor is absorbed and holds the door instead.
        set_mask[cur_floor_q] = 1'b0;
        if (req[cur_floor_q]) begin
          timer_load = 1'b1;
        end else if (timer_done) begin
          timer_load  = 1'b1;
          door_open_d = 1'b0;
          if (ahead) begin
            state_d  = MOVE;
            moving_d = 1'b1;
          end else if (behind) begin
            state_d  = MOVE;
            moving_d = 1'b1;
            dir_up_d = ~dir_up_q;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        moving_d    = 1'b0;
        door_open_d = 1'b0;
      end
    endcase

    pending_d   = (pending_q | set_mask) & ~clr_mask;
    floor_sel_d = {1'b0, cur_floor_d};
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_floor_q <= '0;
      floor_sel_q <= '0;
      dir_up_q    <= 1'b1;
      moving_q    <= 1'b0;
      door_open_q <= 1'b0;
      pending_q   <= '0;
    end else begin
      state_q     <= state_d;
      cur_floor_q <= cur_floor_d;
      floor_sel_q <= floor_sel_d;
      dir_up_q    <= dir_up_d;
      moving_q    <= moving_d;
      door_open_q <= door_open_d;
      pending_q   <= pending_d;
    end
  end

  assign floor_sel = floor_sel_q;
  assign cur_floor = cur_floor_q;
  assign dir_up    = dir_up_q;
  assign moving    = moving_q;
  assign door_open = door_open_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: remaining-ticks reference model compared
// every cycle, directed scenarios with literal expectations, random calls.
module tb_elevator_scheduler;

  localparam int TRAVEL_T = 4;
  localparam int DOOR_T   = 6;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick  = 1'b0;
  logic [7:0] req   = '0;
  logic [3:0] floor_sel;
  logic [2:0] cur_floor;
  logic       dir_up, moving, door_open;
  logic [7:0] pending;

  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 1'b0;
  int   dt = 0;
  int   mt = 0;
  logic door_prev = 1'b0;
  logic moving_prev = 1'b0;

  always #5 clk = ~clk;

  elevator_scheduler #(
    .FLOORS       (8),
    .TRAVEL_TICKS (TRAVEL_T),
    .DOOR_TICKS   (DOOR_T)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .req       (req),
    .floor_sel (floor_sel),
    .cur_floor (cur_floor),
    .dir_up    (dir_up),
    .moving    (moving),
    .door_open (door_open),
    .pending   (pending)
  );

  // Reference model: mode 0 idle, 1 travelling, 2 door open; m_left counts
  // the tick pulses still owed in the current interval.
  int       m_mode  = 0;
  int       m_floor = 0;
  int       m_left  = 0;
  bit       m_dir   = 1'b1;
  bit [7:0] m_pend  = '0;

  function automatic bit pend_in(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if (i >= 0 && i <= 7 && m_pend[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit [7:0] np;
    bit       up_calls, down_calls;
    if (!rst_n) begin
      m_mode = 0; m_floor = 0; m_left = 0; m_dir = 1'b1; m_pend = '0;
    end else begin
      np         = m_pend | req;
      up_calls   = pend_in(m_floor + 1, 7);
      down_calls = pend_in(0, m_floor - 1);
      case (m_mode)
        0: begin
          if (m_pend[m_floor]) begin
            m_mode = 2; m_left = DOOR_T; np[m_floor] = 1'b0;
          end else if (up_calls) begin
            m_mode = 1; m_dir = 1'b1; m_left = TRAVEL_T;
          end else if (down_calls) begin
            m_mode = 1; m_dir = 1'b0; m_left = TRAVEL_T;
          end
        end
        1: begin
          if (tick) begin
            m_left--;
            if (m_left == 0) begin
              m_floor = m_dir ? m_floor + 1 : m_floor - 1;
              m_left  = TRAVEL_T;
              if (m_pend[m_floor]) begin
                m_mode = 2; m_left = DOOR_T; np[m_floor] = 1'b0;
              end
            end
          end
        end
        default: begin
          np[m_floor] = m_pend[m_floor];
          if (req[m_floor]) begin
            m_left = DOOR_T;
          end else if (tick) begin
            m_left--;
            if (m_left == 0) begin
              if (m_dir ? up_calls : down_calls) begin
                m_mode = 1; m_left = TRAVEL_T;
              end else if (m_dir ? down_calls : up_calls) begin
                m_mode = 1; m_left = TRAVEL_T; m_dir = ~m_dir;
              end else begin
                m_mode = 0;
              end
            end
          end
        end
      endcase
      m_pend = np;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: compare against the model, count interval ticks, drive tick.
  task automatic cyc();
    logic [17:0] dut_vec, mdl_vec;
    @(negedge clk);
    if (chk_en) begin
      dut_vec = {floor_sel, cur_floor, dir_up, moving, door_open, pending};
      mdl_vec = {1'b0, 3'(m_floor), 3'(m_floor), m_dir, (m_mode == 1), (m_mode == 2), m_pend};
      check("cycle_outputs", 32'(dut_vec), 32'(mdl_vec));
    end
    if (tick && door_prev)   dt++;
    if (tick && moving_prev) mt++;
    door_prev   = door_open;
    moving_prev = moving;
    tick = ($urandom_range(0, 2) == 0);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic wait_door(input logic lvl, input string name);
    int n = 0;
    while (door_open !== lvl && n < 2000) begin
      cyc();
      n++;
    end
    tests++;
    if (door_open !== lvl) begin
      fails++;
      $display("FAIL %s: timeout, door_open=%b required %b", name, door_open, lvl);
    end
  endtask

  task automatic wait_floor_moving(input logic [2:0] f, input string name);
    int n = 0;
    while (!(cur_floor === f && moving === 1'b1) && n < 2000) begin
      cyc();
      n++;
    end
    tests++;
    if (!(cur_floor === f && moving === 1'b1)) begin
      fails++;
      $display("FAIL %s: timeout, cur_floor=%0d moving=%b required floor %0d moving", name, cur_floor, moving, f);
    end
  endtask

  initial begin
    int base, mbase, n;
    cyc();
    cyc();
    rst_n  = 1'b1;
    chk_en = 1'b1;

    check("reset_cur_floor", 32'(cur_floor), 0);
    check("reset_floor_sel", 32'(floor_sel), 0);
    check("reset_dir_up",    32'(dir_up), 1);
    check("reset_moving",    32'(moving), 0);
    check("reset_door_open", 32'(door_open), 0);
    check("reset_pending",   32'(pending), 0);

    // Call at the current floor: latched, then door one edge later.
    req = 8'h01;
    cyc();
    req = '0;
    check("s1_latched", 32'(pending), 32'h01);
    check("s1_not_yet_door", 32'(door_open), 0);
    cyc();
    check("s1_door_open", 32'(door_open), 1);
    check("s1_pending_clear", 32'(pending), 0);
    base = dt;
    wait_door(1'b0, "s1_door_close");
    check("s1_door_ticks", 32'(dt - base), 32'(DOOR_T));
    check("s1_idle_moving", 32'(moving), 0);

    // Travel 0 -> 5.
    req = 8'h20;
    cyc();
    req = '0;
    cyc();
    check("s2_moving", 32'(moving), 1);
    check("s2_dir_up", 32'(dir_up), 1);
    mbase = mt;
    n = 0;
    while (cur_floor !== 3'd3 && n < 2000) begin cyc(); n++; end
    check("s2_at3_ticks", 32'(mt - mbase), 32'(3 * TRAVEL_T));
    check("s2_at3_floor_sel", 32'(floor_sel), 32'h3);
    wait_door(1'b1, "s2_door");
    check("s2_floor", 32'(cur_floor), 5);
    check("s2_floor_sel", 32'(floor_sel), 32'h5);
    check("s2_total_ticks", 32'(mt - mbase), 32'(5 * TRAVEL_T));
    check("s2_pending", 32'(pending), 0);
    wait_door(1'b0, "s2_door_close");

    // SCAN: moving up past 3 with calls at 6 and 1.
    do_reset();
    req = 8'h40;
    cyc();
    req = '0;
    wait_floor_moving(3'd3, "s3_reach3");
    req = 8'h02;
    cyc();
    req = '0;
    wait_door(1'b1, "s3_door6");
    check("s3_first_floor", 32'(cur_floor), 6);
    check("s3_first_dir", 32'(dir_up), 1);
    check("s3_pending_1", 32'(pending), 32'h02);
    wait_door(1'b0, "s3_close6");
    wait_door(1'b1, "s3_door1");
    check("s3_second_floor", 32'(cur_floor), 1);
    check("s3_second_dir", 32'(dir_up), 0);
    wait_door(1'b0, "s3_close1");
    check("s3_idle_moving", 32'(moving), 0);
    check("s3_idle_pending", 32'(pending), 0);
    check("s3_idle_dir", 32'(dir_up), 0);

    // Door hold: call at the open floor after 4 ticks.
    req = 8'h02;
    cyc();
    req = '0;
    cyc();
    check("s4_door_open", 32'(door_open), 1);
    base = dt;
    n = 0;
    while ((dt - base) < 4 && n < 2000) begin cyc(); n++; end
    check("s4_still_open", 32'(door_open), 1);
    req = 8'h02;
    cyc();
    req = '0;
    check("s4_not_latched", 32'(pending), 0);
    base = dt;
    wait_door(1'b0, "s4_close");
    check("s4_restart_ticks", 32'(dt - base), 32'(DOOR_T));
    check("s4_pending", 32'(pending), 0);

    // All floors called at once from floor 0.
    do_reset();
    req = 8'hFF;
    cyc();
    req = '0;
    for (int f = 0; f < 8; f++) begin
      wait_door(1'b1, "s5_door");
      check("s5_floor", 32'(cur_floor), 32'(f));
      check("s5_dir_up", 32'(dir_up), 1);
      wait_door(1'b0, "s5_close");
    end
    check("s5_final_pending", 32'(pending), 0);
    check("s5_final_dir", 32'(dir_up), 1);

    // Asynchronous reset while travelling between 2 and 3.
    do_reset();
    req = 8'h80;
    cyc();
    req = '0;
    wait_floor_moving(3'd2, "s6_reach2");
    cyc();
    rst_n = 1'b0;
    #1;
    check("s6_cur_floor", 32'(cur_floor), 0);
    check("s6_floor_sel", 32'(floor_sel), 0);
    check("s6_pending", 32'(pending), 0);
    check("s6_dir_up", 32'(dir_up), 1);
    check("s6_moving", 32'(moving), 0);
    check("s6_door_open", 32'(door_open), 0);
    cyc();
    rst_n = 1'b1;

    // Random calls, occasional resets; model compared every cycle.
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 1499) == 0) begin
        req = '0;
        do_reset();
      end else begin
        req = ($urandom_range(0, 11) == 0) ? (8'($urandom) & 8'($urandom)) : 8'h00;
        cyc();
      end
    end
    req = '0;
    repeat (400) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule
